// File: rtl/pll_reset_sequencer_if.sv
// pll_reset_sequencer_if
// Groups the control and status signals of the PLL reset sequencer.
//   enable       : level, high runs the sequencer
//   restart_req  : single-cycle restart pulse (honoured in RUN or FAIL)
//   pll_locked   : raw PLL locked, asynchronous to clk_74a
//   pll_rst      : PLL reset, active-high
//   ready        : PLL clocks qualified stable
//   fail         : retry budget exhausted
//   lost_lock    : sticky, lock dropped while in RUN
//   retry_count  : retries consumed in the current sequence
// master = environment side, slave = sequencer side.
interface pll_reset_sequencer_if;
  logic       enable;
  logic       restart_req;
  logic       pll_locked;
  logic       pll_rst;
  logic       ready;
  logic       fail;
  logic       lost_lock;
  logic [2:0] retry_count;

  modport master (
    output enable, restart_req, pll_locked,
    input  pll_rst, ready, fail, lost_lock, retry_count
  );

  modport slave (
    input  enable, restart_req, pll_locked,
    output pll_rst, ready, fail, lost_lock, retry_count
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Holds the audio/video PLL in reset, waits for lock with a timeout and
// bounded retries, then requires lock to stay stable before raising ready.
// Loss of lock in RUN re-sequences with a fresh retry budget.
// Ports:
//   clk_74a : 74.25 MHz reference clock
//   reset_n : asynchronous active-low reset
//   pll     : sequencer side of pll_reset_sequencer_if (see interface file)
module pll_reset_sequencer #(
  parameter int unsigned RST_HOLD_CYCLES     = 64,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 1048576,
  parameter int unsigned MAX_RETRIES         = 7
) (
  input  logic                   clk_74a,
  input  logic                   reset_n,
  pll_reset_sequencer_if.slave   pll
);

  localparam int unsigned MAX_HS = (RST_HOLD_CYCLES > LOCK_STABLE_CYCLES) ?
                                   RST_HOLD_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MAX_P  = (MAX_HS > LOCK_TIMEOUT_CYCLES) ?
                                   MAX_HS : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned CW     = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] HOLD_LAST    = CW'(RST_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    RETRY_MAX    = 3'(MAX_RETRIES);

  // One-hot state bit positions, used for direct output decode.
  localparam int unsigned B_IDLE = 0;
  localparam int unsigned B_ARST = 1;
  localparam int unsigned B_RUN  = 4;
  localparam int unsigned B_FAIL = 5;

  typedef enum logic [5:0] {
    ST_IDLE       = 6'b000001,
    ST_ASSERT_RST = 6'b000010,
    ST_WAIT_LOCK  = 6'b000100,
    ST_STABILIZE  = 6'b001000,
    ST_RUN        = 6'b010000,
    ST_FAIL       = 6'b100000
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    retry_q, retry_d;
  logic          lost_q, lost_d;
  logic [1:0]    sync_q;
  logic          locked_s;
  logic          attempt_fail;

  assign locked_s = sync_q[1];

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      retry_q <= '0;
      lost_q  <= 1'b0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      lost_q  <= lost_d;
      sync_q  <= {sync_q[0], pll.pll_locked};
    end
  end

  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    lost_d       = lost_q;
    attempt_fail = 1'b0;

    if (!pll.enable) begin
      state_d = ST_IDLE;
    end else if (pll.restart_req && (state_q == ST_RUN || state_q == ST_FAIL)) begin
      state_d = ST_ASSERT_RST;
      retry_d = '0;
      lost_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ASSERT_RST;
          retry_d = '0;
        end
        ST_ASSERT_RST: begin
          if (cnt_q == HOLD_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (locked_s)                   state_d = ST_STABILIZE;
          else if (cnt_q == TIMEOUT_LAST) attempt_fail = 1'b1;
        end
        ST_STABILIZE: begin
          if (!locked_s)                  attempt_fail = 1'b1;
          else if (cnt_q == STABLE_LAST)  state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!locked_s) begin
            state_d = ST_ASSERT_RST;
            lost_d  = 1'b1;
            retry_d = '0;
          end
        end
        ST_FAIL: state_d = ST_FAIL;
        default: state_d = ST_IDLE;
      endcase

      if (attempt_fail) begin
        if (retry_q == RETRY_MAX) begin
          state_d = ST_FAIL;
        end else begin
          retry_d = retry_q + 3'd1;
          state_d = ST_ASSERT_RST;
        end
      end
    end
  end

  // Counter restarts at zero on every state entry, including re-entry of
  // ASSERT_RST from a failed attempt; it only runs in the timed states.
  always_comb begin
    cnt_d = '0;
    if (state_d == state_q &&
        (state_q == ST_ASSERT_RST || state_q == ST_WAIT_LOCK || state_q == ST_STABILIZE))
      cnt_d = cnt_q + CW'(1);
  end

  assign pll.pll_rst     = state_q[B_IDLE] | state_q[B_ARST] | state_q[B_FAIL];
  assign pll.ready       = state_q[B_RUN];
  assign pll.fail        = state_q[B_FAIL];
  assign pll.lost_lock   = lost_q;
  assign pll.retry_count = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with RST_HOLD=4, LOCK_STABLE=8,
// LOCK_TIMEOUT=32, MAX_RETRIES=2. Inputs change and outputs are sampled
// 1 time unit after each rising edge.
module tb_pll_reset_sequencer;
  logic clk = 1'b0;
  logic reset_n;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  pll_reset_sequencer_if bus ();

  pll_reset_sequencer #(
    .RST_HOLD_CYCLES    (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32),
    .MAX_RETRIES        (2)
  ) dut (
    .clk_74a(clk),
    .reset_n(reset_n),
    .pll    (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic rst, input logic rdy,
                         input logic fl, input logic lost, input logic [2:0] rc);
    chk({tag, ".pll_rst"},     8'(bus.pll_rst),     8'(rst));
    chk({tag, ".ready"},       8'(bus.ready),       8'(rdy));
    chk({tag, ".fail"},        8'(bus.fail),        8'(fl));
    chk({tag, ".lost_lock"},   8'(bus.lost_lock),   8'(lost));
    chk({tag, ".retry_count"}, 8'(bus.retry_count), 8'(rc));
  endtask

  initial begin
    reset_n         = 1'b0;
    bus.enable      = 1'b0;
    bus.restart_req = 1'b0;
    bus.pll_locked  = 1'b0;
    step(3);
    chk_all("reset", 1, 0, 0, 0, 0);
    reset_n = 1'b1;
    step(2);
    chk_all("idle_disabled", 1, 0, 0, 0, 0);

    // Nominal bring-up: 4-cycle reset, lock 10 cycles later, ready 11 edges after lock.
    bus.enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(1);
      chk("rst_hold", 8'(bus.pll_rst), 8'd1);
    end
    step(1);
    chk("rst_release", 8'(bus.pll_rst), 8'd0);
    step(9);
    chk_all("wait_lock", 0, 0, 0, 0, 0);
    bus.pll_locked = 1'b1;
    step(10);
    chk("ready_early", 8'(bus.ready), 8'd0);
    step(1);
    chk_all("nominal_ready", 0, 1, 0, 0, 0);

    // Lock loss in RUN: effect on the 3rd edge.
    bus.pll_locked = 1'b0;
    step(2);
    chk("loss_edge2_ready", 8'(bus.ready), 8'd1);
    step(1);
    chk_all("lock_loss", 1, 0, 0, 1, 0);
    bus.pll_locked = 1'b1;
    step(12);
    chk("relock_early", 8'(bus.ready), 8'd0);
    step(1);
    chk_all("relock", 0, 1, 0, 1, 0);

    // enable low in RUN: IDLE next edge, lost_lock kept.
    bus.enable = 1'b0;
    step(1);
    chk_all("enable_drop_run", 1, 0, 0, 1, 0);
    bus.enable = 1'b1;
    step(13);
    chk("reenable_early", 8'(bus.ready), 8'd0);
    step(1);
    chk_all("reenable", 0, 1, 0, 1, 0);

    // Stabilize glitch at count 5.
    bus.restart_req = 1'b1;
    bus.pll_locked  = 1'b0;
    step(1);
    bus.restart_req = 1'b0;
    chk_all("restart_run", 1, 0, 0, 0, 0);
    step(4);
    chk("glitch_wait", 8'(bus.pll_rst), 8'd0);
    bus.pll_locked = 1'b1;
    step(6);
    bus.pll_locked = 1'b0;
    step(2);
    bus.pll_locked = 1'b1;
    chk_all("glitch_stab", 0, 0, 0, 0, 0);
    step(1);
    chk_all("glitch_fail", 1, 0, 0, 0, 1);
    step(3);
    chk("glitch_rst_hold", 8'(bus.pll_rst), 8'd1);
    step(1);
    chk("glitch_rst_release", 8'(bus.pll_rst), 8'd0);
    step(8);
    chk("glitch_ready_early", 8'(bus.ready), 8'd0);
    step(1);
    chk_all("glitch_ready", 0, 1, 0, 0, 1);

    // Timeout to FAIL: 3 attempts of 36 cycles.
    bus.restart_req = 1'b1;
    bus.pll_locked  = 1'b0;
    step(1);
    bus.restart_req = 1'b0;
    chk_all("restart_timeout", 1, 0, 0, 0, 0);
    step(4);
    chk("att0_wait", 8'(bus.pll_rst), 8'd0);
    step(31);
    chk_all("att0_end", 0, 0, 0, 0, 0);
    step(1);
    chk_all("att1_start", 1, 0, 0, 0, 1);
    step(35);
    chk_all("att1_end", 0, 0, 0, 0, 1);
    step(1);
    chk_all("att2_start", 1, 0, 0, 0, 2);
    step(35);
    chk_all("att2_end", 0, 0, 0, 0, 2);
    step(1);
    chk_all("fail_entry", 1, 0, 1, 0, 2);
    step(20);
    chk_all("fail_hold", 1, 0, 1, 0, 2);

    // Recovery from FAIL, ignored restart in WAIT_LOCK, enable drop mid-WAIT_LOCK.
    bus.restart_req = 1'b1;
    step(1);
    bus.restart_req = 1'b0;
    chk_all("restart_fail", 1, 0, 0, 0, 0);
    step(4);
    chk("recov_wait", 8'(bus.pll_rst), 8'd0);
    step(3);
    bus.restart_req = 1'b1;
    step(1);
    bus.restart_req = 1'b0;
    chk("restart_ignored", 8'(bus.pll_rst), 8'd0);
    step(2);
    bus.enable = 1'b0;
    step(1);
    chk_all("enable_drop_wait", 1, 0, 0, 0, 0);

    // Async reset mid-STABILIZE with lost_lock set.
    bus.enable     = 1'b1;
    bus.pll_locked = 1'b1;
    step(13);
    chk("pre_reset_early", 8'(bus.ready), 8'd0);
    step(1);
    chk("pre_reset_ready", 8'(bus.ready), 8'd1);
    bus.pll_locked = 1'b0;
    step(3);
    chk_all("pre_reset_loss", 1, 0, 0, 1, 0);
    bus.pll_locked = 1'b1;
    step(7);
    chk_all("pre_reset_stab", 0, 0, 0, 1, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("async_reset", 1, 0, 0, 0, 0);
    step(2);
    chk_all("reset_held", 1, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
